// File: rtl/serial_tx_pkg.sv
// Shared serial-link definitions: line-coding state encodings and line idle level.
// Imported by the transmitter today and intended for the matching receiver.
// No ports; types and constants only.
package serial_tx_pkg;

  // The four base states fit in 2 bits; PARITY = 4 widens the encoding to 3 bits.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  // Level of the serial line when no frame is in flight (also the stop-bit level).
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count of each period.
// Ports: clk, asyncReset (async, active-high), clear (restart period at 0), tick (last count).
// With CLKS_PER_BIT=1 the count is constantly 0 and tick is always high.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic asyncReset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial UART-style frame transmitter: start, data LSB first, optional even parity, stop.
// Ports: clk, asyncReset (async, active-high); tx_data/tx_valid/tx_ready accept handshake;
//        tx_out registered idle-high line, tx_busy frame in progress, tx_done one-cycle completion pulse.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              asyncReset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state, state_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              par, par_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              out_nxt;
  logic              done_nxt;
  logic              clear;
  logic              tick;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .asyncReset(asyncReset),
    .clear     (clear),
    .tick      (tick)
  );

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      state   <= IDLE;
      shift   <= '0;
      par     <= 1'b0;
      idx     <= '0;
      tx_out  <= LINE_IDLE;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      par     <= par_nxt;
      idx     <= idx_nxt;
      tx_out  <= out_nxt;
      tx_done <= done_nxt;
    end
  end

  // tx_out is computed one step ahead so the register presents each line bit
  // from the very edge on which the state advances into it.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    par_nxt   = par;
    idx_nxt   = idx;
    out_nxt   = tx_out;
    done_nxt  = 1'b0;
    clear     = 1'b0;

    case (state)
      IDLE: begin
        out_nxt = LINE_IDLE;
        if (tx_valid) begin
          shift_nxt = tx_data;
          par_nxt   = ^tx_data;
          state_nxt = START;
          out_nxt   = 1'b0;
          // Restart the bit period so the start bit lasts a full CLKS_PER_BIT.
          clear     = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          state_nxt = DATA;
          idx_nxt   = '0;
          out_nxt   = shift[0];
        end
      end

      DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              out_nxt   = par;
            end else begin
              state_nxt = STOP;
              out_nxt   = LINE_IDLE;
            end
          end else begin
            shift_nxt = shift >> 1;
            idx_nxt   = idx + 1'b1;
            out_nxt   = shift_nxt[0];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          out_nxt   = LINE_IDLE;
        end
      end

      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          out_nxt   = LINE_IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        out_nxt   = LINE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed self-checking bench for serial_tx in three configurations:
// a = (8 bits, 4 clk/bit, no parity), b = (8, 4, even parity), c = (1 bit, 1 clk/bit, no parity).
module tb_serial_tx;

  logic clk;
  logic asyncReset;

  logic [7:0] a_data;
  logic       a_valid, a_ready, a_out, a_busy, a_done;
  logic [7:0] b_data;
  logic       b_valid, b_ready, b_out, b_busy, b_done;
  logic [0:0] c_data;
  logic       c_valid, c_ready, c_out, c_busy, c_done;

  int n_cmp = 0;
  int n_err = 0;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
    .clk(clk), .asyncReset(asyncReset), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_out(a_out), .tx_busy(a_busy), .tx_done(a_done)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_b (
    .clk(clk), .asyncReset(asyncReset), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_out(b_out), .tx_busy(b_busy), .tx_done(b_done)
  );

  serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
    .clk(clk), .asyncReset(asyncReset), .tx_data(c_data), .tx_valid(c_valid),
    .tx_ready(c_ready), .tx_out(c_out), .tx_busy(c_busy), .tx_done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    asyncReset = 1'b1;
    #13;
    n_cmp++;
    if ({a_out, a_busy, a_done, a_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL reset_a: out/busy/done/ready=%b expected 1001", {a_out, a_busy, a_done, a_ready});
    end
    n_cmp++;
    if ({b_out, b_busy, b_done, b_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL reset_b: out/busy/done/ready=%b expected 1001", {b_out, b_busy, b_done, b_ready});
    end
    n_cmp++;
    if ({c_out, c_busy, c_done, c_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL reset_c: out/busy/done/ready=%b expected 1001", {c_out, c_busy, c_done, c_ready});
    end
    #10 asyncReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({a_out, a_ready, b_out, b_ready, c_out, c_ready} !== 6'b111111) begin
      n_err++;
      $display("FAIL reset_idle_after_release: got %b expected 111111",
               {a_out, a_ready, b_out, b_ready, c_out, c_ready});
    end
  endtask

  // 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 (index 0 = start bit).
  task automatic test_single_frame();
    logic [9:0] f = 10'b1101001010;
    a_data = 8'hA5;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_data = 8'h00;
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (a_out !== f[k/4] || a_done !== 1'b0 || a_busy !== 1'b1 || a_ready !== 1'b0) begin
        n_err++;
        $display("FAIL single_a5 cycle %0d: out=%b done=%b busy=%b ready=%b expected out=%b done=0 busy=1 ready=0",
                 k, a_out, a_done, a_busy, a_ready, f[k/4]);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (a_done !== 1'b1 || a_out !== 1'b1 || a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_a5_done at 40: done=%b out=%b ready=%b expected 1 1 1", a_done, a_out, a_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (a_done !== 1'b0 || a_out !== 1'b1) begin
      n_err++;
      $display("FAIL single_a5_after: done=%b out=%b expected 0 1", a_done, a_out);
    end
  endtask

  // 0x07 -> parity 1, 0x03 -> parity 0; 11 line bits x 4 = 44 cycles.
  task automatic test_parity();
    logic [10:0] fr [2];
    logic [7:0]  d  [2];
    fr[0] = 11'b11000001110; d[0] = 8'h07;
    fr[1] = 11'b10000000110; d[1] = 8'h03;
    for (int t = 0; t < 2; t++) begin
      b_data = d[t];
      b_valid = 1'b1;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      for (int k = 0; k < 44; k++) begin
        n_cmp++;
        if (b_out !== fr[t][k/4] || b_done !== 1'b0) begin
          n_err++;
          $display("FAIL parity_%h cycle %0d: out=%b done=%b expected out=%b done=0",
                   d[t], k, b_out, b_done, fr[t][k/4]);
        end
        @(posedge clk);
        #1;
      end
      n_cmp++;
      if (b_done !== 1'b1 || b_out !== 1'b1 || b_ready !== 1'b1) begin
        n_err++;
        $display("FAIL parity_%h_done at 44: done=%b out=%b ready=%b expected 1 1 1",
                 d[t], b_done, b_out, b_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Valid held high across two frames: one idle-high gap cycle with tx_ready=1.
  task automatic test_back_to_back();
    logic [9:0] f1 = 10'b1000000000;
    logic [9:0] f2 = 10'b1111111110;
    a_data = 8'h00;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_data = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (a_out !== f1[k/4] || a_ready !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_first cycle %0d: out=%b ready=%b expected out=%b ready=0", k, a_out, a_ready, f1[k/4]);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (a_done !== 1'b1 || a_ready !== 1'b1 || a_out !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_gap: done=%b ready=%b out=%b expected 1 1 1", a_done, a_ready, a_out);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (a_out !== f2[k/4] || a_ready !== 1'b0 || a_done !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_second cycle %0d: out=%b ready=%b done=%b expected out=%b ready=0 done=0",
                 k, a_out, a_ready, a_done, f2[k/4]);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (a_done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_done: done=%b expected 1", a_done);
    end
    @(posedge clk);
    #1;
  endtask

  // A request arriving mid-frame is dropped, not queued.
  task automatic test_ignored_request();
    logic [9:0] f = 10'b1100000010;
    int dones = 0;
    a_data = 8'h81;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        a_data = 8'h3C;
        a_valid = 1'b1;
      end
      if (k == 11) a_valid = 1'b0;
      n_cmp++;
      if (a_out !== f[k/4]) begin
        n_err++;
        $display("FAIL ignored_81 cycle %0d: out=%b expected %b", k, a_out, f[k/4]);
      end
      if (a_done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 12; k++) begin
      if (a_done === 1'b1) dones++;
      n_cmp++;
      if (a_out !== 1'b1 || a_busy !== 1'b0) begin
        n_err++;
        $display("FAIL ignored_tail cycle %0d: out=%b busy=%b expected 1 0", k, a_out, a_busy);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL ignored_done_count: got %0d pulses expected 1", dones);
    end
  endtask

  // DATA_W=1, CLKS_PER_BIT=1, send 1: line 0,1,1 then tx_done on the third edge.
  task automatic test_one_clk_per_bit();
    logic [2:0] f = 3'b110;
    c_data = 1'b1;
    c_valid = 1'b1;
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (c_out !== f[k] || c_done !== 1'b0 || c_busy !== 1'b1) begin
        n_err++;
        $display("FAIL cpb1 cycle %0d: out=%b done=%b busy=%b expected out=%b done=0 busy=1",
                 k, c_out, c_done, c_busy, f[k]);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (c_done !== 1'b1 || c_out !== 1'b1 || c_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cpb1_done: done=%b out=%b ready=%b expected 1 1 1", c_done, c_out, c_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted during data bit 3 of a 0x00 frame (line low) returns the line high without a clock.
  task automatic test_reset_mid_frame();
    a_data = 8'h00;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    n_cmp++;
    if (a_out !== 1'b0 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre: out=%b busy=%b expected 0 1", a_out, a_busy);
    end
    asyncReset = 1'b1;
    #2;
    n_cmp++;
    if (a_out !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async: out=%b busy=%b ready=%b done=%b expected 1 0 1 0",
               a_out, a_busy, a_ready, a_done);
    end
    #1 asyncReset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (a_out !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) begin
        n_err++;
        $display("FAIL midreset_after cycle %0d: out=%b busy=%b done=%b expected 1 0 0",
                 k, a_out, a_busy, a_done);
      end
    end
  endtask

  initial begin
    a_data = '0; a_valid = 1'b0;
    b_data = '0; b_valid = 1'b0;
    c_data = '0; c_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_ignored_request();
    test_one_clk_per_bit();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
